// File: rtl/taxi_sfp_mgr.sv
// rtl/taxi_sfp_mgr.sv - per-cage SFP presence/fault manager with debounced inputs and TX enable sequencing
// Optional statistics counters: define TAXI_SFP_MGR_STAT_CNT_EN.
module taxi_sfp_mgr #(
    parameter int PORTS           = 2,
    parameter int DEBOUNCE_CYCLES = 125000,
    parameter int INSERT_DELAY    = 62500,
    parameter int FAULT_HOLDOFF   = 125000,
    parameter int MAX_RETRIES     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PORTS-1:0]      sfp_npres,
    input  logic [PORTS-1:0]      sfp_los,
    input  logic [PORTS-1:0]      sfp_tx_fault,
    input  logic [PORTS-1:0]      port_en,
    input  logic [PORTS-1:0]      rate_sel,
    input  logic [PORTS-1:0]      fault_clear,
    output logic [PORTS-1:0]      sfp_tx_disable,
    output logic [PORTS-1:0][1:0] sfp_rs,
    output logic [PORTS-1:0]      stat_present,
    output logic [PORTS-1:0]      stat_active,
    output logic [PORTS-1:0]      stat_link_up,
    output logic [PORTS-1:0]      stat_lockout
`ifdef TAXI_SFP_MGR_STAT_CNT_EN
    ,
    output logic [PORTS-1:0][7:0] stat_insert_cnt,
    output logic [PORTS-1:0][7:0] stat_fault_cnt
`endif
);

    localparam int TMR_MAX = (INSERT_DELAY > FAULT_HOLDOFF) ? INSERT_DELAY : FAULT_HOLDOFF;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_ABSENT, ST_INSERT_WAIT, ST_ACTIVE, ST_HOLDOFF, ST_LOCKOUT
    } state_t;

    for (genvar i = 0; i < PORTS; i++) begin : g_port
        // Bit 0 = npres, bit 1 = los, bit 2 = tx_fault; reset value means absent, los, no fault.
        logic [2:0]           raw, sync1, sync2, filt;
        logic [2:0][DB_W-1:0] db_cnt;
        logic                 present, los, fault;
        state_t               state, state_nx;
        logic [TMR_W-1:0]     tmr, tmr_nx;
        logic [3:0]           retry, retry_nx;
        logic                 td_nx, active_nx, link_nx, lock_nx;
        logic                 td_q, active_q, link_q, lock_q, present_q;
        logic [1:0]           rs_q;

        assign raw     = {sfp_tx_fault[i], sfp_los[i], sfp_npres[i]};
        assign present = ~filt[0];
        assign los     = filt[1];
        assign fault   = filt[2];

        always_ff @(posedge clk) begin
            if (rst) begin
                sync1  <= 3'b011;
                sync2  <= 3'b011;
                filt   <= 3'b011;
                db_cnt <= '0;
            end else begin
                sync1 <= raw;
                sync2 <= sync1;
                for (int j = 0; j < 3; j++) begin
                    if (sync2[j] == filt[j]) begin
                        db_cnt[j] <= '0;
                    end else if (db_cnt[j] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        filt[j]   <= sync2[j];
                        db_cnt[j] <= '0;
                    end else begin
                        db_cnt[j] <= db_cnt[j] + DB_W'(1);
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state <= ST_ABSENT;
                tmr   <= '0;
                retry <= '0;
            end else begin
                state <= state_nx;
                tmr   <= tmr_nx;
                retry <= retry_nx;
            end
        end

        // Removal / disable is checked first so it beats fault, fault_clear and timer expiry.
        always_comb begin
            state_nx = state;
            tmr_nx   = (tmr != '0) ? tmr - TMR_W'(1) : '0;
            retry_nx = retry;
            if (!present || !port_en[i]) begin
                state_nx = ST_ABSENT;
                tmr_nx   = '0;
                retry_nx = '0;
            end else begin
                case (state)
                    ST_ABSENT: begin
                        state_nx = ST_INSERT_WAIT;
                        tmr_nx   = TMR_W'(INSERT_DELAY);
                    end
                    ST_INSERT_WAIT: begin
                        if (tmr <= TMR_W'(1)) state_nx = ST_ACTIVE;
                    end
                    ST_ACTIVE: begin
                        if (fault) begin
                            state_nx = ST_HOLDOFF;
                            tmr_nx   = TMR_W'(FAULT_HOLDOFF);
                            retry_nx = (retry == 4'hf) ? retry : retry + 4'd1;
                        end
                    end
                    ST_HOLDOFF: begin
                        if (tmr <= TMR_W'(1))
                            state_nx = (retry < 4'(MAX_RETRIES)) ? ST_ACTIVE : ST_LOCKOUT;
                    end
                    ST_LOCKOUT: begin
                        if (fault_clear[i]) begin
                            state_nx = ST_ABSENT;
                            retry_nx = '0;
                        end
                    end
                    default: state_nx = ST_ABSENT;
                endcase
            end
        end

        always_comb begin
            td_nx     = (state != ST_ACTIVE);
            active_nx = (state == ST_ACTIVE);
            link_nx   = (state == ST_ACTIVE) && !los;
            lock_nx   = (state == ST_LOCKOUT);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                td_q      <= 1'b1;
                active_q  <= 1'b0;
                link_q    <= 1'b0;
                lock_q    <= 1'b0;
                present_q <= 1'b0;
                rs_q      <= 2'b00;
            end else begin
                td_q      <= td_nx;
                active_q  <= active_nx;
                link_q    <= link_nx;
                lock_q    <= lock_nx;
                present_q <= present;
                rs_q      <= {rate_sel[i], rate_sel[i]};
            end
        end

        assign sfp_tx_disable[i] = td_q;
        assign sfp_rs[i]         = rs_q;
        assign stat_present[i]   = present_q;
        assign stat_active[i]    = active_q;
        assign stat_link_up[i]   = link_q;
        assign stat_lockout[i]   = lock_q;

`ifdef TAXI_SFP_MGR_STAT_CNT_EN
        logic [7:0] ins_cnt, flt_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                ins_cnt <= '0;
                flt_cnt <= '0;
            end else begin
                if (state == ST_ABSENT && state_nx == ST_INSERT_WAIT && ins_cnt != 8'hff)
                    ins_cnt <= ins_cnt + 8'd1;
                if (state == ST_ACTIVE && state_nx == ST_HOLDOFF && flt_cnt != 8'hff)
                    flt_cnt <= flt_cnt + 8'd1;
            end
        end

        assign stat_insert_cnt[i] = ins_cnt;
        assign stat_fault_cnt[i]  = flt_cnt;
`endif
    end

endmodule

// File: doc/taxi_sfp_mgr.md
TAXI_SFP_MGR -- requirements
Module: taxi_sfp_mgr

Interface
REQ-001 The block SHALL have parameter PORTS, default 2: number of SFP cages managed (1..16).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 125000: stable cycles required before a filtered input changes.
REQ-003 The block SHALL have parameter INSERT_DELAY, default 62500: cycles from filtered insertion to TX enable.
REQ-004 The block SHALL have parameter FAULT_HOLDOFF, default 125000: cycles the TX stays disabled after a fault.
REQ-005 The block SHALL have parameter MAX_RETRIES, default 3: faults tolerated before lockout (1..15).
REQ-006 The block SHALL have ports: clk in 1 system clock; rst in 1 reset; one clock, reset synchronous and active-high.
REQ-007 The block SHALL have ports: sfp_npres in [PORTS] presence, low = present; sfp_los in [PORTS] loss of signal; sfp_tx_fault in [PORTS] module fault. All three are asynchronous.
REQ-008 The block SHALL have ports: port_en in [PORTS] software enable; rate_sel in [PORTS] 1 = 10G rate; fault_clear in [PORTS] single-cycle lockout-clear pulse.
REQ-009 The block SHALL have ports: sfp_tx_disable out [PORTS]; sfp_rs out [PORTS] 2-bit rate select.
REQ-010 The block SHALL have ports: stat_present, stat_active, stat_link_up, stat_lockout, each out [PORTS] 1 bit.

Function
REQ-011 Each asynchronous input SHALL pass through a 2-FF synchronizer and then a per-port debounce counter; the filtered value SHALL change only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any intervening match SHALL reload the counter.
REQ-012 Each port SHALL run an independent FSM with states ABSENT, INSERT_WAIT, ACTIVE, HOLDOFF, LOCKOUT.
REQ-013 ABSENT -> INSERT_WAIT SHALL occur when filtered present & port_en; the delay counter is loaded with INSERT_DELAY.
REQ-014 INSERT_WAIT -> ACTIVE SHALL occur when the delay counter expires, i.e. exactly INSERT_DELAY cycles after entry.
REQ-015 ACTIVE -> HOLDOFF SHALL occur on filtered fault; the retry count increments (saturating at 15); the counter is loaded with FAULT_HOLDOFF.
REQ-016 On HOLDOFF expiry, the FSM SHALL go to ACTIVE if retry count < MAX_RETRIES, else to LOCKOUT.
REQ-017 LOCKOUT SHALL be left only by a fault_clear pulse, to ABSENT, with the retry count cleared.
REQ-018 Filtered removal or port_en low SHALL force ABSENT from any state within 1 cycle and clear the retry count; this has priority over fault, fault_clear and timer expiry on the same cycle.
REQ-019 sfp_tx_disable SHALL be registered: 0 only in ACTIVE, 1 in all other states; the update lands 1 cycle after the state change.
REQ-020 sfp_rs SHALL be registered {rate_sel, rate_sel}, with 1 cycle latency, independent of FSM state.
REQ-021 The status outputs SHALL be registered: stat_present = filtered present; stat_active = ACTIVE; stat_link_up = ACTIVE & ~filtered los; stat_lockout = LOCKOUT.
REQ-022 Filtered los SHALL NOT affect FSM transitions.
REQ-023 fault_clear outside LOCKOUT SHALL be ignored.

Reset
REQ-024 rst SHALL be synchronous and active-high.
REQ-025 While rst is asserted: all FSMs ABSENT; synchronizers and filtered values = absent, los asserted, no fault; debounce, delay and retry counters 0.
REQ-026 While rst is asserted: sfp_tx_disable all 1; sfp_rs all 0; all stat outputs 0.
REQ-027 rst asserted mid-operation SHALL take effect on the next edge regardless of state, including ACTIVE and LOCKOUT.

Configuration
REQ-028 With TAXI_SFP_MGR_STAT_CNT_EN defined, the block SHALL add outputs stat_insert_cnt and stat_fault_cnt [PORTS] 8-bit saturating counters, incremented on ABSENT->INSERT_WAIT and ACTIVE->HOLDOFF respectively, and cleared by rst.
REQ-029 Without TAXI_SFP_MGR_STAT_CNT_EN, those ports and counters SHALL be absent, with all other behaviour identical.

Verification (PORTS=2, DEBOUNCE_CYCLES=8, INSERT_DELAY=16, FAULT_HOLDOFF=32, MAX_RETRIES=2)
REQ-030 Bench SHALL cover insertion: port0 npres 1->0, port_en=1 -> stat_present=1 after 2+8 cycles; sfp_tx_disable[0]=0 16 cycles later; port1 is unaffected.
REQ-031 Bench SHALL cover glitch rejection: npres pulsed low for 5 cycles -> no state change, stat_present stays 0.
REQ-032 Bench SHALL cover fault retry: tx_fault asserted in ACTIVE -> tx_disable=1 for 32 cycles, then 0; a second fault leads to LOCKOUT, stat_lockout=1; a fault_clear pulse returns to ABSENT and then re-inserts.
REQ-033 Bench SHALL cover priority: removal debounced on the same cycle as a HOLDOFF expiry -> ABSENT, retry count 0, tx_disable=1.
REQ-034 Bench SHALL cover link status: in ACTIVE, los 1->0 -> stat_link_up=1 after 10 cycles; los 0->1 leaves stat_active=1.
REQ-035 Bench SHALL cover mid-operation reset: rst during ACTIVE -> next cycle tx_disable=1, stat outputs 0, and counters 0 if TAXI_SFP_MGR_STAT_CNT_EN is defined.
